div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider in the execute stage of the MIPS core. It executes DIV and DIVU and is the producer side of the HI/LO register interface. On completion it drives the quotient on `lo`, the remainder on `hi`, and a one-cycle `hilo_we = 2'b11` pulse that the HI/LO register file captures. While it runs, its `busy` output stalls the pipeline.

---
 rtl/cpu_defs.sv | 25 ++
 rtl/div_step.sv | 39 +++
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared execute-stage definitions for the divider and HI/LO write path
//
// Purpose: state encoding of the divide FSM, divide latency constant and the
//          HI/LO write-enable codes shared with MTHI/MTLO decode.
// Ports:   none (package).

package cpu_defs;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  // {hi_we, lo_we}
  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    DZERO = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
//
// Purpose: shifts {rem, quo} left by one, trial-subtracts the divisor and
//          keeps the difference when it is non-negative.
// Ports:
//   rem_in   partial remainder before the step
//   quo_in   quotient register before the step (still holds unshifted dividend bits)
//   divisor  divisor magnitude
//   rem_out  partial remainder after the step
//   quo_out  quotient register after the step

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the extra MSB of the difference is the borrow/sign.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_out    = diff[WIDTH-1:0];
      quo_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring DIV/DIVU unit feeding the HI/LO register file
//
// Purpose: divides opdata1 by opdata2 one bit per cycle; quotient to lo,
//          remainder to hi, with a one-cycle hilo_we = 2'b11 write pulse.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       division request, sampled only in IDLE
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   annul       flush; aborts a running operation without a write
//   opdata1     dividend (rs)
//   opdata2     divisor (rt)
//   busy        high during the iterative phase, stalls the pipeline
//   done        one-cycle completion pulse
//   hilo_we     {hi_we, lo_we}, 2'b11 only in the done cycle
//   hi, lo      remainder and quotient, held until the next completion

module div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic             busy,
  output logic             done,
  output logic [1:0]       hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] mag1, mag2;
  logic             sign1, sign2;
  logic             last_step;
  logic             accept;

  assign sign1 = signed_div & opdata1[WIDTH-1];
  assign sign2 = signed_div & opdata2[WIDTH-1];
  // The most negative value maps onto itself, which as an unsigned magnitude
  // is exactly right, so the overflow case needs no special handling.
  assign mag1  = sign1 ? -opdata1 : opdata1;
  assign mag2  = sign2 ? -opdata2 : opdata2;

  assign accept    = (state == IDLE) && start && !annul;
  assign last_step = (cnt == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus outputs decoded from state alone.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    hilo_we   = HILO_WE_NONE;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (opdata2 == '0) ? DZERO : DIV;
        end
      end
      DIV: begin
        busy = 1'b1;
        if (annul) begin
          state_nxt = IDLE;
        end else if (last_step) begin
          state_nxt = DONE;
        end
      end
      DZERO: begin
        state_nxt = annul ? IDLE : DONE;
      end
      DONE: begin
        // annul cannot cancel a write that is already being presented.
        done      = 1'b1;
        hilo_we   = HILO_WE_BOTH;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && (opdata2 != '0)) begin
            dvsr  <= mag2;
            quo   <= mag1;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sign1 ^ sign2;
            neg_r <= sign1;
          end
        end
        DIV: begin
          if (!annul) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CW'(1);
            if (last_step) begin
              lo <= neg_q ? -quo_nxt : quo_nxt;
              hi <= neg_r ? -rem_nxt : rem_nxt;
            end
          end
        end
        DZERO: begin
          if (!annul) begin
            hi <= '0;
            lo <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit

module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        busy;
  logic        done;
  logic [1:0]  hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .busy       (busy),
    .done       (done),
    .hilo_we    (hilo_we),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    int          exp_done_cyc;
    int          exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // start is sampled at edge 0; samples are taken on the negedge of cycle N.
  task automatic run_vec(input vec_t v);
    int busy_cnt, done_cyc, ndone, we_bad;
    logic [31:0] got_lo, got_hi;
    logic [1:0]  got_we;
    busy_cnt = 0; done_cyc = 0; ndone = 0; we_bad = 0;
    got_lo = '0; got_hi = '0; got_we = '0;
    @(negedge clk);
    signed_div = v.sgn; opdata1 = v.a; opdata2 = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (done_cyc == 0) begin
          done_cyc = cyc; got_lo = lo; got_hi = hi; got_we = hilo_we;
        end
      end else if (hilo_we != 2'b00) begin
        we_bad++;
      end
      if (done_cyc != 0 && cyc == done_cyc + 2) break;
    end
    chk({v.name, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done_cyc));
    chk({v.name, " busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
    chk({v.name, " lo"}, got_lo, v.exp_lo);
    chk({v.name, " hi"}, got_hi, v.exp_hi);
    chk({v.name, " hilo_we"}, 32'(got_we), 32'h3);
    chk({v.name, " done_count"}, 32'(ndone), 32'd1);
    chk({v.name, " stray_we"}, 32'(we_bad), 32'd0);
    chk({v.name, " lo_held"}, lo, v.exp_lo);
    chk({v.name, " hi_held"}, hi, v.exp_hi);
  endtask

  initial begin
    int ndone, nwe, k;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;

    vecs[0] = '{"divu_100_7",    1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        33, 32};
    vecs[1] = '{"div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 33, 32};
    vecs[2] = '{"div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        33, 32};
    vecs[3] = '{"divu_5_0",      1'b0, 32'd5,          32'd0,        32'd0,         32'd0,        2,  0};
    vecs[4] = '{"div_overflow",  1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        33, 32};
    vecs[5] = '{"divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        33, 32};
    vecs[6] = '{"divu_fff9_2",   1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,  32'd1,        33, 32};
    vecs[7] = '{"div_m100_m7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 33, 32};
    vecs[8] = '{"divu_3_10",     1'b0, 32'd3,          32'd10,       32'd0,         32'd3,        33, 32};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hilo_we", 32'(hilo_we), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // annul in cycle 10, restart in cycle 11
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ndone = 0; nwe = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) ndone++;
      if (hilo_we != 2'b00) nwe++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    if (done) ndone++;
    if (hilo_we != 2'b00) nwe++;
    chk("annul busy_c11", 32'(busy), 32'd0);
    chk("annul no_done", 32'(ndone), 32'd0);
    chk("annul no_we", 32'(nwe), 32'd0);
    opdata1 = 32'd1000; opdata2 = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("annul restart busy", 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("annul restart latency", 32'(k), 32'd32);
    chk("annul restart lo", lo, 32'd100);
    chk("annul restart hi", hi, 32'd0);

    // start pulse during DIV is ignored
    @(negedge clk);
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd200; opdata2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ndone = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 5) begin
        start = 1'b1; opdata1 = 32'd77; opdata2 = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        chk("ignored_start done_cycle", 32'(cyc), 32'd33);
      end
    end
    chk("ignored_start done_count", 32'(ndone), 32'd1);
    chk("ignored_start lo", lo, 32'd22);
    chk("ignored_start hi", hi, 32'd2);

    // reset in cycle 20
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 20; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hilo_we", 32'(hilo_we), 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || hilo_we != 2'b00) ndone++;
    end
    chk("midrst no_write", 32'(ndone), 32'd0);

    // start together with annul in IDLE
    @(negedge clk);
    opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    chk("start_annul busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done || hilo_we != 2'b00) ndone++;
    end
    chk("start_annul no_op", 32'(ndone), 32'd0);
    chk("start_annul lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
